stream_credit_tx: RTL and testbench
===================================

Name: stream_credit_tx

Overview:
Credit-based stream transmitter. It accepts items on an upstream valid/ready handshake and pushes them downstream on a valid-only interface. It sends only while it holds a credit for a free slot in the remote receive buffer. The receiver returns one credit per consumed item. The output is fully registered, and ready_o depends only on internal state, so no combinational path exists from any input to any output.

Parameters:
T, logic, payload data type.
NumCredits, 2, receive-buffer slots at the remote end; legal range 1..255; elaboration-time assertion if outside.
CntWidth, $clog2(NumCredits+1), credit counter width (derived; must not be overridden).

Ports:
clk_i  input  1  clock; all state on rising edge.
rst_i  input  1  synchronous active-high reset.
valid_i  input  1  upstream item valid.
ready_o  output  1  transmitter accepts item this cycle.
data_i  input  T  upstream payload.
valid_o  output  1  downstream push strobe, one cycle per item.
data_o  output  T  downstream payload, qualified by valid_o.
credit_i  input  1  one credit returned this cycle.
credit_avail_o  output  CntWidth  current credit count.
credit_err_o  output  1  sticky credit-overflow error.
idle_o  output  1  all credits home and no push in flight.

Behaviour:
- Reset (rst_i=1 at a clock edge): credit_q=NumCredits, valid_o=0, data_o='0, credit_err_o=0. rst_i has priority over every other input in that cycle.
- Reset mid-operation discards in-flight credits. The receiver must be reset in the same cycle.
- Send condition: send = valid_i && ready_o.
- ready_o = (credit_q != 0). It is purely a function of registered state.
- Upstream handshake: once valid_i is asserted, upstream holds valid_i and data_i stable until accepted. The transmitter does not depend on this, but the bench checks it.
- Latency: exactly 1 cycle. When send occurs in cycle N, valid_o=1 and data_o=data_i(N) in cycle N+1.
- valid_o is registered from send. It is high for exactly one cycle per accepted item. Back-to-back sends give continuous valid_o.
- data_o register loads only on send. It holds its last value while valid_o=0.
- Credit update: credit_d = credit_q - send + credit_i, computed at CntWidth+1 bits.
  - Send and credit_i in the same cycle: count unchanged.
  - Credit reaches 0 after a send: ready_o drops in the next cycle. A credit_i in that same cycle keeps it at 1, so ready_o stays high.
- Overflow: credit_i=1 with no send while credit_q==NumCredits.
  - credit_q saturates at NumCredits.
  - credit_err_o sets in the next cycle and stays high until reset.
- Underflow cannot occur because send requires credit_q>0.
- credit_avail_o = credit_q (registered).
- idle_o = (credit_q==NumCredits) && !valid_o.
- No other states exist. The credit counter plus the output register form the complete state.

Test Plan:
- Reset then idle, NumCredits=2: after rst_i pulse -> credit_avail_o=2, ready_o=1, valid_o=0, data_o=0, idle_o=1, credit_err_o=0.
- Exhaust credits: valid_i=1 with data 0xA then 0xB on consecutive cycles, no credit_i -> valid_o high for 2 cycles carrying 0xA, 0xB; credit_avail_o 2->1->0; ready_o=0 from the third cycle; a third item 0xC is held and valid_o stays 0.
- Credit return unblocks: from the blocked state, pulse credit_i one cycle -> ready_o=1 next cycle; 0xC is accepted and appears on data_o one cycle later; credit_avail_o returns to 0.
- Simultaneous send and return at credit_avail_o=1: valid_i=1 and credit_i=1 in the same cycle -> count stays 1, ready_o stays 1; sustained this way, a 10-item burst streams with valid_o continuous for 10 cycles.
- Overflow: at credit_avail_o=2 with no send, credit_i=1 -> credit_avail_o stays 2; credit_err_o=1 next cycle and remains 1 over 20 cycles until rst_i.
- Reset mid-burst: rst_i asserted while credit_avail_o=0 and valid_i=1 -> next cycle credit_avail_o=2, valid_o=0, credit_err_o=0; the item presented during the reset cycle is not transmitted.

Source files
------------

// File: rtl/stream_credit_tx.sv
// Credit-based stream transmitter: upstream valid/ready in, registered valid-only push out,
// gated by a local count of free slots in the remote receive buffer.
module stream_credit_tx #(
    parameter type T = logic,
    parameter int NumCredits = 2,
    localparam int unsigned CntWidth = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  T                    data_i,
    output logic                valid_o,
    output T                    data_o,
    input  logic                credit_i,
    output logic [CntWidth-1:0] credit_avail_o,
    output logic                credit_err_o,
    output logic                idle_o
);

    localparam int unsigned SumW = CntWidth + 1;
    localparam logic [CntWidth-1:0] FullCnt = CntWidth'(NumCredits);

    if (NumCredits < 1 || NumCredits > 255) begin : g_bad_num_credits
        $error("stream_credit_tx: NumCredits=%0d outside 1..255", NumCredits);
    end

    logic [CntWidth-1:0] credit_q;
    logic [CntWidth-1:0] credit_d;
    logic [SumW-1:0]     credit_sum;
    logic                valid_q;
    T                    data_q;
    logic                err_q;
    logic                send;
    logic                overflow;

    // Next credit count; the extra bit exposes a return that would exceed the buffer size.
    always_comb begin
        send       = 1'b0;
        credit_sum = '0;
        overflow   = 1'b0;
        credit_d   = credit_q;

        send       = valid_i && (credit_q != '0);
        credit_sum = SumW'(credit_q) - SumW'(send) + SumW'(credit_i);
        overflow   = credit_sum > {1'b0, FullCnt};
        credit_d   = overflow ? FullCnt : credit_sum[CntWidth-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q <= FullCnt;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            valid_q  <= send;
            if (send) begin
                data_q <= data_i;
            end
            if (overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    // Everything below depends only on registers, keeping inputs off every output path.
    assign ready_o        = (credit_q != '0);
    assign valid_o        = valid_q;
    assign data_o         = data_q;
    assign credit_avail_o = credit_q;
    assign credit_err_o   = err_q;
    assign idle_o         = (credit_q == FullCnt) && !valid_q;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Bench for stream_credit_tx: directed scenarios plus random traffic, all checked against
// an integer credit/queue model of the transmitter.
module tb_stream_credit_tx;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic       credit_i;
    logic [1:0] credit_avail_o;
    logic       credit_err_o;
    logic       idle_o;

    int total = 0;
    int bad   = 0;

    // Model state: free remote slots as a plain integer, plus the observed output stream.
    int         m_cred;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_err;
    int         remote_items;

    always #5 clk = ~clk;

    stream_credit_tx #(
        .T          (logic [7:0]),
        .NumCredits (N)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .credit_i       (credit_i),
        .credit_avail_o (credit_avail_o),
        .credit_err_o   (credit_err_o),
        .idle_o         (idle_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare everything.
    task automatic tick();
        bit send;
        @(posedge clk);
        if (rst_i) begin
            m_cred       = N;
            m_valid      = 1'b0;
            m_data       = 8'h00;
            m_err        = 1'b0;
            remote_items = 0;
        end else begin
            send   = valid_i && (m_cred > 0);
            m_cred = m_cred - int'(send) + int'(credit_i);
            if (m_cred > N) begin
                m_cred = N;
                m_err  = 1'b1;
            end
            m_valid = send;
            if (send) begin
                m_data = data_i;
                remote_items++;
            end
        end
        #1;
        check("credit_avail", 32'(credit_avail_o), 32'(m_cred));
        check("ready",        32'(ready_o),        32'(m_cred != 0));
        check("valid_o",      32'(valid_o),        32'(m_valid));
        check("data_o",       32'(data_o),         32'(m_data));
        check("credit_err",   32'(credit_err_o),   32'(m_err));
        check("idle",         32'(idle_o),         32'(m_cred == N && !m_valid));
    endtask

    initial begin
        bit acc;
        rst_i    = 1'b1;
        valid_i  = 1'b0;
        data_i   = 8'h00;
        credit_i = 1'b0;
        remote_items = 0;
        tick();
        rst_i = 1'b0;
        tick();

        // Reset then idle
        check("rst_credit", 32'(credit_avail_o), 32'd2);
        check("rst_ready",  32'(ready_o),        32'd1);
        check("rst_valid",  32'(valid_o),        32'd0);
        check("rst_data",   32'(data_o),         32'd0);
        check("rst_idle",   32'(idle_o),         32'd1);
        check("rst_err",    32'(credit_err_o),   32'd0);

        // Exhaust credits
        valid_i = 1'b1; data_i = 8'h0A; tick();
        check("ex_a_valid", 32'(valid_o), 32'd1);
        check("ex_a_data",  32'(data_o),  32'h0A);
        check("ex_a_cred",  32'(credit_avail_o), 32'd1);
        data_i = 8'h0B; tick();
        check("ex_b_data",  32'(data_o),  32'h0B);
        check("ex_b_cred",  32'(credit_avail_o), 32'd0);
        check("ex_b_ready", 32'(ready_o), 32'd0);
        data_i = 8'h0C; tick();
        check("ex_c_held",  32'(valid_o), 32'd0);
        tick();
        check("ex_c_held2", 32'(valid_o), 32'd0);

        // Credit return unblocks the held item
        credit_i = 1'b1; tick();
        credit_i = 1'b0;
        check("ret_ready", 32'(ready_o), 32'd1);
        check("ret_novalid", 32'(valid_o), 32'd0);
        tick();
        valid_i = 1'b0;
        check("ret_c_valid", 32'(valid_o), 32'd1);
        check("ret_c_data",  32'(data_o),  32'h0C);
        check("ret_c_cred",  32'(credit_avail_o), 32'd0);

        // Simultaneous send and return at one credit: continuous 10-item burst
        credit_i = 1'b1; tick();
        check("sim_cred1", 32'(credit_avail_o), 32'd1);
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = 8'(8'h10 + i);
            tick();
            check("burst_valid", 32'(valid_o), 32'd1);
            check("burst_data",  32'(data_o),  32'(8'h10 + i));
            check("burst_cred",  32'(credit_avail_o), 32'd1);
        end
        valid_i = 1'b0;
        tick();
        check("burst_end", 32'(valid_o), 32'd0);
        credit_i = 1'b0;

        // Overflow is sticky until reset
        check("ov_full", 32'(credit_avail_o), 32'd2);
        credit_i = 1'b1; tick();
        credit_i = 1'b0;
        check("ov_sat", 32'(credit_avail_o), 32'd2);
        check("ov_err", 32'(credit_err_o), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check("ov_sticky", 32'(credit_err_o), 32'd1);

        // Reset mid-burst drops the item presented during reset
        rst_i = 1'b1; tick();
        rst_i = 1'b0;
        valid_i = 1'b1; data_i = 8'h21; tick();
        data_i = 8'h22; tick();
        check("mid_cred0", 32'(credit_avail_o), 32'd0);
        data_i = 8'hEE; rst_i = 1'b1; tick();
        rst_i = 1'b0; valid_i = 1'b0;
        check("mid_cred",  32'(credit_avail_o), 32'd2);
        check("mid_valid", 32'(valid_o), 32'd0);
        check("mid_err",   32'(credit_err_o), 32'd0);
        tick();
        check("mid_drop",  32'(valid_o), 32'd0);

        // Random traffic with a well-behaved receiver and a stable-until-accepted upstream
        for (int c = 0; c < 3000; c++) begin
            acc = valid_i && !rst_i && (m_cred > 0);
            tick();
            rst_i = ($urandom_range(0, 299) == 0);
            if (acc || !valid_i) begin
                valid_i = ($urandom_range(0, 3) != 0);
                data_i  = 8'($urandom);
            end
            credit_i = 1'b0;
            if (remote_items > 0 && $urandom_range(0, 2) == 0) begin
                credit_i = 1'b1;
                remote_items--;
            end
        end
        rst_i = 1'b0; valid_i = 1'b0; credit_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
